// File: rtl/control_barrido_display_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan controller.
// Contents:
//   NUM_DIGITOS     number of scanned slots (five digits plus sign)
//   SEG_0..SEG_9    active-low {g,f,e,d,c,b,a} patterns for the decimal digits
//   SEG_APAGADO     all segments off
//   SEG_MENOS       only segment g lit (minus sign)
//   estado_t        load/scan handshake states
//   anodo_de_slot   one-hot-low anode pattern for a slot number
package pkg_display;

  localparam int NUM_DIGITOS = 6;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;
  localparam logic [6:0] SEG_MENOS   = 7'b0111111;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    MOSTRANDO = 2'd1,
    PENDIENTE = 2'd2
  } estado_t;

  // Slot n pulls anodo[n] low; anything outside 0..5 leaves every digit dark.
  function automatic logic [7:0] anodo_de_slot(input logic [2:0] slot);
    logic [7:0] patron;
    case (slot)
      3'd0:    patron = 8'b1111_1110;
      3'd1:    patron = 8'b1111_1101;
      3'd2:    patron = 8'b1111_1011;
      3'd3:    patron = 8'b1111_0111;
      3'd4:    patron = 8'b1110_1111;
      3'd5:    patron = 8'b1101_1111;
      default: patron = 8'b1111_1111;
    endcase
    return patron;
  endfunction

endpackage

// File: rtl/control_barrido_display_decodificador_7seg.sv
// BCD to active-low seven-segment decoder, purely combinational.
// Ports:
//   i_bcd    BCD digit; codes 10..15 produce a blank digit
//   i_apagar force the digit blank (leading-zero suppression)
//   o_seg    active-low {g,f,e,d,c,b,a}
module decodificador_7seg
  import pkg_display::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_apagar,
  output logic [6:0] o_seg
);

  // Map the digit to its segment pattern unless blanking is requested.
  always_comb begin
    o_seg = SEG_APAGADO;
    if (i_apagar) begin
      o_seg = SEG_APAGADO;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_APAGADO;
      endcase
    end
  end

endmodule

// File: rtl/control_barrido_display.sv
// Multiplexed-scan controller for the signed BCD product display.
// A result (five BCD digits plus sign) is accepted through a valid/ready
// handshake. The first result goes live immediately; later results are
// buffered and only become active on the frame wrap so a frame never mixes
// two values. Six slots (units..ten-thousands, sign) are scanned, each held
// for DIV_REFRESCO cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cargar_valido         a new result is offered
//   cargar_listo          a result can be accepted this cycle
//   bcd_in, signo_in      offered magnitude (5 BCD digits) and sign (1 = negative)
//   contador_actualizar   current slot 0..5
//   anodo                 active-low digit enables (registered)
//   segmentos             active-low {g,f,e,d,c,b,a} (registered)
module control_barrido_display
  import pkg_display::*;
#(
  parameter int DIV_REFRESCO = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cargar_valido,
  output logic        cargar_listo,
  input  logic [19:0] bcd_in,
  input  logic        signo_in,
  output logic [2:0]  contador_actualizar,
  output logic [7:0]  anodo,
  output logic [6:0]  segmentos
);

  localparam int ANCHO_PRE = (DIV_REFRESCO > 2) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [ANCHO_PRE-1:0] PRE_TOPE    = ANCHO_PRE'(DIV_REFRESCO - 1);
  localparam logic [2:0]           SLOT_ULTIMO = 3'(NUM_DIGITOS - 1);

  estado_t               r_estado;
  estado_t               w_estado_sig;
  logic [ANCHO_PRE-1:0]  r_pre;
  logic [2:0]            r_slot;
  logic [19:0]           r_bcd_act;
  logic                  r_signo_act;
  logic [19:0]           r_bcd_pend;
  logic                  r_signo_pend;
  logic                  r_listo;
  logic [7:0]            r_anodo;
  logic [6:0]            r_seg;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_transferencia;
  logic                  w_cargar_act;
  logic                  w_cargar_pend;
  logic                  w_copiar_pend;
  logic [3:0]            w_digito;
  logic                  w_apagar_dig;
  logic [6:0]            w_seg_dig;
  logic [6:0]            w_seg_slot;

  assign cargar_listo        = r_listo;
  assign contador_actualizar = r_slot;
  assign anodo               = r_anodo;
  assign segmentos           = r_seg;

  // The scan only runs once something has been loaded.
  assign w_tick          = (r_estado != INACTIVO) && (r_pre == PRE_TOPE);
  assign w_wrap          = w_tick && (r_slot == SLOT_ULTIMO);
  assign w_transferencia = cargar_valido && r_listo;

  // Next-state and data-steering decisions of the load handshake.
  always_comb begin
    w_estado_sig  = r_estado;
    w_cargar_act  = 1'b0;
    w_cargar_pend = 1'b0;
    w_copiar_pend = 1'b0;
    case (r_estado)
      INACTIVO: begin
        if (w_transferencia) begin
          w_cargar_act = 1'b1;
          w_estado_sig = MOSTRANDO;
        end else begin
          w_estado_sig = INACTIVO;
        end
      end
      MOSTRANDO: begin
        // A load coinciding with the wrap still waits a full frame.
        if (w_transferencia) begin
          w_cargar_pend = 1'b1;
          w_estado_sig  = PENDIENTE;
        end else begin
          w_estado_sig = MOSTRANDO;
        end
      end
      PENDIENTE: begin
        if (w_wrap) begin
          w_copiar_pend = 1'b1;
          w_estado_sig  = MOSTRANDO;
        end else begin
          w_estado_sig = PENDIENTE;
        end
      end
      default: begin
        w_estado_sig = INACTIVO;
      end
    endcase
  end

  // State register; ready is registered from the next state so it tracks it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= INACTIVO;
      r_listo  <= 1'b1;
    end else begin
      r_estado <= w_estado_sig;
      r_listo  <= (w_estado_sig != PENDIENTE);
    end
  end

  // Refresh prescaler and slot counter, both parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_slot <= 3'd0;
    end else if (r_estado == INACTIVO) begin
      r_pre  <= '0;
      r_slot <= 3'd0;
    end else if (w_tick) begin
      r_pre  <= '0;
      r_slot <= (r_slot == SLOT_ULTIMO) ? 3'd0 : (r_slot + 3'd1);
    end else begin
      r_pre  <= r_pre + ANCHO_PRE'(1);
      r_slot <= r_slot;
    end
  end

  // Active (displayed) and pending (buffered) result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_act    <= 20'h00000;
      r_signo_act  <= 1'b0;
      r_bcd_pend   <= 20'h00000;
      r_signo_pend <= 1'b0;
    end else begin
      if (w_cargar_act) begin
        r_bcd_act   <= bcd_in;
        r_signo_act <= signo_in;
      end else if (w_copiar_pend) begin
        r_bcd_act   <= r_bcd_pend;
        r_signo_act <= r_signo_pend;
      end else begin
        r_bcd_act   <= r_bcd_act;
        r_signo_act <= r_signo_act;
      end
      if (w_cargar_pend) begin
        r_bcd_pend   <= bcd_in;
        r_signo_pend <= signo_in;
      end else begin
        r_bcd_pend   <= r_bcd_pend;
        r_signo_pend <= r_signo_pend;
      end
    end
  end

  // Pick the digit for the current slot; higher digits blank while they and everything above are zero.
  always_comb begin
    w_digito     = 4'h0;
    w_apagar_dig = 1'b1;
    case (r_slot)
      3'd0: begin
        w_digito     = r_bcd_act[3:0];
        w_apagar_dig = 1'b0;
      end
      3'd1: begin
        w_digito     = r_bcd_act[7:4];
        w_apagar_dig = (r_bcd_act[19:4] == 16'h0000);
      end
      3'd2: begin
        w_digito     = r_bcd_act[11:8];
        w_apagar_dig = (r_bcd_act[19:8] == 12'h000);
      end
      3'd3: begin
        w_digito     = r_bcd_act[15:12];
        w_apagar_dig = (r_bcd_act[19:12] == 8'h00);
      end
      3'd4: begin
        w_digito     = r_bcd_act[19:16];
        w_apagar_dig = (r_bcd_act[19:16] == 4'h0);
      end
      default: begin
        w_digito     = 4'h0;
        w_apagar_dig = 1'b1;
      end
    endcase
  end

  decodificador_7seg u_decodificador (
    .i_bcd    (w_digito),
    .i_apagar (w_apagar_dig),
    .o_seg    (w_seg_dig)
  );

  // Sign slot: minus only for a nonzero negative magnitude, so -0 shows as "0".
  always_comb begin
    w_seg_slot = w_seg_dig;
    if (r_slot == SLOT_ULTIMO) begin
      w_seg_slot = (r_signo_act && (r_bcd_act != 20'h00000)) ? SEG_MENOS : SEG_APAGADO;
    end else begin
      w_seg_slot = w_seg_dig;
    end
  end

  // Output registers: one cycle behind the slot counter, dark while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anodo <= 8'hFF;
      r_seg   <= SEG_APAGADO;
    end else if (r_estado == INACTIVO) begin
      r_anodo <= 8'hFF;
      r_seg   <= SEG_APAGADO;
    end else begin
      r_anodo <= anodo_de_slot(r_slot);
      r_seg   <= w_seg_slot;
    end
  end

endmodule

// File: tb/tb_control_barrido_display.sv
// Bench for control_barrido_display with DIV_REFRESCO = 4.
// The stimulus thread pushes the expected {anode, segments} of each slot it
// expects to see; a monitor pops one entry every time a new slot appears on
// the anodes and also checks that each slot stays lit for exactly 4 cycles.
module tb_control_barrido_display;

  localparam int DIV = 4;

  localparam logic [6:0] E_0  = 7'b1000000;
  localparam logic [6:0] E_1  = 7'b1111001;
  localparam logic [6:0] E_2  = 7'b0100100;
  localparam logic [6:0] E_3  = 7'b0110000;
  localparam logic [6:0] E_4  = 7'b0011001;
  localparam logic [6:0] E_5  = 7'b0010010;
  localparam logic [6:0] E_7  = 7'b1111000;
  localparam logic [6:0] E_9  = 7'b0010000;
  localparam logic [6:0] E_BL = 7'h7F;
  localparam logic [6:0] E_MN = 7'b0111111;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } esperado_t;

  logic        clk;
  logic        rst_n;
  logic        cargar_valido;
  logic        cargar_listo;
  logic [19:0] bcd_in;
  logic        signo_in;
  logic [2:0]  contador_actualizar;
  logic [7:0]  anodo;
  logic [6:0]  segmentos;

  int        errors = 0;
  int        checks = 0;
  bit        mon_en = 1'b0;
  esperado_t cola[$];

  control_barrido_display #(.DIV_REFRESCO(DIV)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cargar_valido       (cargar_valido),
    .cargar_listo        (cargar_listo),
    .bcd_in              (bcd_in),
    .signo_in            (signo_in),
    .contador_actualizar (contador_actualizar),
    .anodo               (anodo),
    .segmentos           (segmentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nom, act, esp, $time);
    end
  endtask

  task automatic falla(input string nom);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nom, $time);
  endtask

  task automatic esperar(input int slot, input logic [6:0] seg);
    esperado_t e;
    e.an  = ~(8'h01 << slot);
    e.seg = seg;
    cola.push_back(e);
  endtask

  task automatic reiniciar();
    mon_en        = 1'b0;
    cargar_valido = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one offer for exactly one rising edge; call just after a falling edge.
  task automatic cargar(input logic [19:0] b, input logic s);
    bcd_in        = b;
    signo_in      = s;
    cargar_valido = 1'b1;
    @(negedge clk);
    cargar_valido = 1'b0;
  endtask

  task automatic drenar(input string nom);
    int n;
    n = 0;
    while (cola.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cola.size() != 0) begin
      falla(nom);
      cola.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic chk_inactivo(input string nom);
    chk({nom, "_anodo"}, 32'(anodo), 32'h0FF);
    chk({nom, "_seg"},   32'(segmentos), 32'h07F);
    chk({nom, "_listo"}, 32'(cargar_listo), 32'h1);
    chk({nom, "_slot"},  32'(contador_actualizar), 32'h0);
  endtask

  // Monitor: a change of the anode pattern marks a new slot on the pins.
  initial begin : monitor
    logic [7:0] prev_an;
    int         duracion;
    esperado_t  e;
    prev_an  = 8'hFF;
    duracion = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_an  = 8'hFF;
        duracion = 0;
      end else begin
        if (anodo !== prev_an) begin
          if (prev_an != 8'hFF && anodo != 8'hFF)
            chk("duracion_slot", 32'(duracion), 32'(DIV));
          if (anodo != 8'hFF) begin
            if (cola.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL slot_inesperado: got anodo %0h with nothing expected", anodo);
            end else begin
              e = cola.pop_front();
              chk("anodo_slot", 32'(anodo), 32'(e.an));
              chk("seg_slot", 32'(segmentos), 32'(e.seg));
            end
          end
          duracion = 1;
        end else begin
          duracion++;
        end
        prev_an = anodo;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : estimulo
    logic [2:0] c_prev;
    bit         hit;
    int         n;
    rst_n         = 1'b0;
    cargar_valido = 1'b0;
    bcd_in        = 20'h00000;
    signo_in      = 1'b0;

    // Reset then idle: dark display, ready, slot 0.
    reiniciar();
    repeat (50) @(negedge clk);
    chk_inactivo("idle");

    // 12345 negative: two full frames.
    mon_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      esperar(0, E_5); esperar(1, E_4); esperar(2, E_3);
      esperar(3, E_2); esperar(4, E_1); esperar(5, E_MN);
    end
    cargar(20'h12345, 1'b1);
    drenar("frames_12345");

    // -7 then -0 buffered behind it: blanking and negative zero.
    reiniciar();
    mon_en = 1'b1;
    esperar(0, E_7); esperar(1, E_BL); esperar(2, E_BL);
    esperar(3, E_BL); esperar(4, E_BL); esperar(5, E_MN);
    esperar(0, E_0); esperar(1, E_BL); esperar(2, E_BL);
    esperar(3, E_BL); esperar(4, E_BL); esperar(5, E_BL);
    cargar(20'h00007, 1'b1);
    cargar(20'h00000, 1'b1);
    drenar("frames_7_0");

    // Mid-frame update of a positive 12345 to 99.
    reiniciar();
    mon_en = 1'b1;
    esperar(0, E_5); esperar(1, E_4); esperar(2, E_3);
    esperar(3, E_2); esperar(4, E_1); esperar(5, E_BL);
    esperar(0, E_9); esperar(1, E_9); esperar(2, E_BL);
    esperar(3, E_BL); esperar(4, E_BL); esperar(5, E_BL);
    cargar(20'h12345, 1'b0);
    repeat (9) @(negedge clk);
    bcd_in        = 20'h00099;
    signo_in      = 1'b0;
    cargar_valido = 1'b1;
    @(negedge clk);
    chk("listo_cae", 32'(cargar_listo), 32'h0);
    repeat (2) @(negedge clk);
    cargar_valido = 1'b0;
    hit    = 1'b0;
    n      = 0;
    c_prev = contador_actualizar;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      if (cargar_listo) begin
        hit = 1'b1;
        chk("listo_sube_slot", 32'(contador_actualizar), 32'h0);
        chk("listo_sube_prev", 32'(c_prev), 32'h5);
      end
      c_prev = contador_actualizar;
    end
    if (!hit) falla("listo_sube");
    drenar("frames_update");

    // Reset in PENDIENTE at slot 3: immediate, buffered data dropped.
    reiniciar();
    cargar(20'h12345, 1'b1);
    cargar(20'h00099, 1'b0);
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 60) begin
      if (contador_actualizar == 3'd3) hit = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!hit) falla("esperar_slot3");
    chk("pendiente_listo", 32'(cargar_listo), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_inactivo("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_inactivo("post_reset");

    // Invalid code in the units digit blanks only slot 0.
    reiniciar();
    mon_en = 1'b1;
    esperar(0, E_BL); esperar(1, E_4); esperar(2, E_3);
    esperar(3, E_2); esperar(4, E_1); esperar(5, E_BL);
    cargar(20'h1234C, 1'b0);
    drenar("frame_1234C");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
